play_mode_ctrl: RTL and testbench

Top-level mode sequencer and buzzer arbiter for the electronic-keyboard design. It debounces the front-panel mode buttons and steps a small state machine through menu, free-play, auto-play and learn modes. It grants the single buzzer path (note + octave) to exactly one of the three player blocks and drives their enables. Every mode change inserts a fixed silent gap so no partial note leaks between sources.

---
 rtl/play_mode_ctrl.sv | 160 ++++++++++++++++
 tb/tb_play_mode_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/play_mode_ctrl.sv
// Mode sequencer and buzzer arbiter: debounces the panel buttons, walks the
// menu/play state machine and grants the buzzer path to one player at a time.
module play_mode_ctrl #(
  parameter int DEBOUNCE   = 200000,
  parameter int GAP_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       confirm_btn,
  input  logic       back_btn,
  input  logic [3:0] free_note,
  input  logic [3:0] auto_note,
  input  logic [3:0] learn_note,
  input  logic [1:0] free_octave,
  input  logic [1:0] auto_octave,
  input  logic [1:0] learn_octave,
  input  logic       auto_done,
  output logic [3:0] note_to_play,
  output logic [1:0] octave_out,
  output logic [1:0] mode_sel,
  output logic [1:0] active_mode,
  output logic       free_en,
  output logic       auto_en,
  output logic       learn_en
);

  // state | meaning
  // IDLE  | menu, mode_btn previews, confirm_btn launches
  // GAP   | silent hold of GAP_CYCLES before entering target
  // FREE  | free player granted
  // AUTO  | auto player granted, auto_done returns to menu
  // LEARN | learn player granted

  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GAP, FREE, AUTO, LEARN} state_t;

  logic [2:0]            raw, sync_a, sync_b, level, press;
  logic [2:0][DB_W-1:0]  db_cnt;
  logic                  press_mode, press_confirm, press_back;

  state_t                state, state_nx, target, target_nx;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  mode_inc;

  assign raw           = {back_btn, confirm_btn, mode_btn};
  assign press_mode    = press[0];
  assign press_confirm = press[1];
  assign press_back    = press[2];

  // Counter runs only while the synchronized level disagrees with the accepted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      level  <= '0;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync_b[i];
          press[i]  <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    mode_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (press_confirm) begin
          state_nx  = GAP;
          target_nx = (mode_sel == 2'd0) ? FREE :
                      (mode_sel == 2'd1) ? AUTO : LEARN;
        end else if (press_mode) begin
          mode_inc = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = target;
      end
      FREE, LEARN: begin
        if (press_back) begin
          state_nx  = GAP;
          target_nx = IDLE;
        end
      end
      AUTO: begin
        if (press_back || auto_done) begin
          state_nx  = GAP;
          target_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so grant and release land on the transition edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      target       <= IDLE;
      gap_cnt      <= '0;
      mode_sel     <= 2'd0;
      active_mode  <= 2'd3;
      note_to_play <= 4'd0;
      octave_out   <= 2'b00;
      free_en      <= 1'b0;
      auto_en      <= 1'b0;
      learn_en     <= 1'b0;
    end else begin
      state   <= state_nx;
      target  <= target_nx;
      gap_cnt <= (state == GAP && state_nx == GAP) ? gap_cnt + 1'b1 : '0;
      if (mode_inc) mode_sel <= (mode_sel == 2'd2) ? 2'd0 : mode_sel + 2'd1;
      free_en  <= (state_nx == FREE);
      auto_en  <= (state_nx == AUTO);
      learn_en <= (state_nx == LEARN);
      case (state_nx)
        FREE: begin
          active_mode  <= 2'd0;
          note_to_play <= free_note;
          octave_out   <= free_octave;
        end
        AUTO: begin
          active_mode  <= 2'd1;
          note_to_play <= auto_note;
          octave_out   <= auto_octave;
        end
        LEARN: begin
          active_mode  <= 2'd2;
          note_to_play <= learn_note;
          octave_out   <= learn_octave;
        end
        default: begin
          active_mode  <= 2'd3;
          note_to_play <= 4'd0;
          octave_out   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_play_mode_ctrl.sv
// Bench for play_mode_ctrl with DEBOUNCE=4, GAP_CYCLES=3: vector table through a
// scoreboard queue, plus exact-cycle sequences for gap, exit and reset behaviour.
module tb_play_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0, confirm_btn = 1'b0, back_btn = 1'b0;
  logic [3:0] free_note = 4'd3, auto_note = 4'd5, learn_note = 4'd7;
  logic [1:0] free_octave = 2'b01, auto_octave = 2'b10, learn_octave = 2'b01;
  logic       auto_done = 1'b0;
  logic [3:0] note_to_play;
  logic [1:0] octave_out, mode_sel, active_mode;
  logic       free_en, auto_en, learn_en;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         act;   // 0 mode, 1 confirm, 2 back, 3 mode glitch, 4 all three
    logic [1:0] sel;
    logic [1:0] amode;
    logic [3:0] note;
    logic [1:0] oct;
  } vec_t;

  vec_t vecs[13];
  vec_t sb_q[$];

  play_mode_ctrl #(.DEBOUNCE(4), .GAP_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .mode_btn(mode_btn), .confirm_btn(confirm_btn), .back_btn(back_btn),
    .free_note(free_note), .auto_note(auto_note), .learn_note(learn_note),
    .free_octave(free_octave), .auto_octave(auto_octave), .learn_octave(learn_octave),
    .auto_done(auto_done),
    .note_to_play(note_to_play), .octave_out(octave_out),
    .mode_sel(mode_sel), .active_mode(active_mode),
    .free_en(free_en), .auto_en(auto_en), .learn_en(learn_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic hold(input logic [2:0] mask, input int n);
    {back_btn, confirm_btn, mode_btn} = mask;
    repeat (n) @(negedge clk);
    {back_btn, confirm_btn, mode_btn} = 3'b000;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    vec_t e;
    int   en_exp;
    v = vecs[i];
    sb_q.push_back(v);
    case (v.act)
      0:       hold(3'b001, 10);
      1:       hold(3'b010, 10);
      2:       hold(3'b100, 10);
      3:       hold(3'b001, 3);
      default: hold(3'b111, 10);
    endcase
    repeat (12) @(negedge clk);
    e = sb_q.pop_front();
    en_exp = int'({e.amode == 2'd2, e.amode == 2'd1, e.amode == 2'd0});
    check($sformatf("v%0d mode_sel", i), int'(mode_sel), int'(e.sel));
    check($sformatf("v%0d active_mode", i), int'(active_mode), int'(e.amode));
    check($sformatf("v%0d note", i), int'(note_to_play), int'(e.note));
    check($sformatf("v%0d octave", i), int'(octave_out), int'(e.oct));
    check($sformatf("v%0d enables", i), int'({learn_en, auto_en, free_en}), en_exp);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("one_enable", int'($countones({free_en, auto_en, learn_en}) <= 1), 1);
      if (active_mode == 2'd3) check("silent_note", int'(note_to_play), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 2'd1, 2'd3, 4'd0, 2'b00};
    vecs[1]  = '{0, 2'd2, 2'd3, 4'd0, 2'b00};
    vecs[2]  = '{0, 2'd0, 2'd3, 4'd0, 2'b00};
    vecs[3]  = '{3, 2'd0, 2'd3, 4'd0, 2'b00};
    vecs[4]  = '{0, 2'd1, 2'd3, 4'd0, 2'b00};
    vecs[5]  = '{3, 2'd1, 2'd3, 4'd0, 2'b00};
    vecs[6]  = '{4, 2'd1, 2'd1, 4'd5, 2'b10};
    vecs[7]  = '{2, 2'd1, 2'd3, 4'd0, 2'b00};
    vecs[8]  = '{0, 2'd2, 2'd3, 4'd0, 2'b00};
    vecs[9]  = '{1, 2'd2, 2'd2, 4'd7, 2'b01};
    vecs[10] = '{0, 2'd2, 2'd2, 4'd7, 2'b01};
    vecs[11] = '{1, 2'd0, 2'd0, 4'd3, 2'b01};
    vecs[12] = '{2, 2'd0, 2'd3, 4'd0, 2'b00};

    repeat (3) @(negedge clk);
    check("rst mode_sel", int'(mode_sel), 0);
    check("rst active_mode", int'(active_mode), 3);
    check("rst note", int'(note_to_play), 0);
    check("rst octave", int'(octave_out), 0);
    check("rst enables", int'({learn_en, auto_en, free_en}), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i <= 5; i++) run_vec(i);

    // confirm with mode_sel=1: press lands on edge 6, GAP on edges 7..9, AUTO from edge 10
    confirm_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("entry k%0d active_mode", k), int'(active_mode), (k >= 10) ? 1 : 3);
      check($sformatf("entry k%0d auto_en", k), int'(auto_en), (k >= 10) ? 1 : 0);
      check($sformatf("entry k%0d note", k), int'(note_to_play), (k >= 10) ? 5 : 0);
    end
    auto_note = 4'd9;
    #1;
    check("note before edge", int'(note_to_play), 5);
    @(negedge clk);
    check("note after edge", int'(note_to_play), 9);
    check("octave auto", int'(octave_out), 2);
    auto_note = 4'd5;
    confirm_btn = 1'b0;
    repeat (10) @(negedge clk);

    auto_done = 1'b1;
    @(posedge clk);
    #1;
    auto_done = 1'b0;
    check("done auto_en", int'(auto_en), 0);
    check("done note", int'(note_to_play), 0);
    check("done active_mode", int'(active_mode), 3);
    repeat (4) @(negedge clk);
    check("done mode_sel", int'(mode_sel), 1);
    check("done idle active", int'(active_mode), 3);

    for (int i = 6; i <= 10; i++) run_vec(i);

    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async learn_en", int'(learn_en), 0);
    check("async note", int'(note_to_play), 0);
    check("async active_mode", int'(active_mode), 3);
    check("async mode_sel", int'(mode_sel), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post-rst mode_sel", int'(mode_sel), 0);
    check("post-rst active_mode", int'(active_mode), 3);

    for (int i = 11; i <= 12; i++) run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
